// File: rtl/led_blink_scheduler_if.sv
// Request/grant bundle between LED requesters and the blink scheduler.
// The master side owns req/cnt_in; the scheduler (slave) drives everything else.
interface led_blink_scheduler_if #(
    parameter int NREQ = 4,
    parameter int BW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*BW-1:0] cnt_in;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic [2:0]         done_id;
    logic               y;

    // req is a level held by a requester until it sees done with its own id;
    // gnt is one-hot for the current owner and done is a single-cycle pulse.
    modport master (
        output req, cnt_in,
        input  gnt, busy, done, done_id, y
    );

    modport slave (
        input  req, cnt_in,
        output gnt, busy, done, done_id, y
    );
endinterface

// File: rtl/led_blink_scheduler.sv
// Round-robin arbiter that lends one LED to NREQ requesters, plays the
// owner's burst of blinks at a fixed half-period and enforces a dark gap.
module led_blink_scheduler #(
    parameter int NREQ        = 4,
    parameter int BW          = 4,
    parameter int CW          = 16,
    parameter int HALF_PERIOD = 25000,
    parameter int GAP         = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    led_blink_scheduler_if.slave  bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] HP_T  = CW'(HALF_PERIOD);
    localparam logic [CW-1:0] GAP_T = CW'(GAP);

    state_t          state_q, state_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   remaining_q, remaining_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]      owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      done_id_q, done_id_d;

    logic            found;
    logic [2:0]      winner;
    logic [NREQ-1:0] win_oh;
    logic [BW-1:0]   win_cnt;
    logic            owner_req;

    // First pass looks at rr_ptr..NREQ-1; if nothing is there, any request
    // left must sit below rr_ptr, so a plain low-to-high scan completes the wrap.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_oh  = '0;
        win_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i] && (3'(i) >= rr_ptr_q)) begin
                found      = 1'b1;
                winner     = 3'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_cnt    = bus.cnt_in[i*BW +: BW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i]) begin
                found      = 1'b1;
                winner     = 3'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_cnt    = bus.cnt_in[i*BW +: BW];
            end
        end
    end

    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        y_d         = y_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = win_oh;
                    remaining_d = win_cnt;
                    owner_d     = winner;
                    rr_ptr_d    = (winner == 3'(NREQ-1)) ? 3'd0 : winner + 3'd1;
                    state_d     = S_ON;
                    timer_d     = CW'(1);
                    // A zero count parks in ON with the LED dark for one cycle.
                    y_d         = (win_cnt != '0);
                end
            end
            S_ON: begin
                timer_d = timer_q + 1'b1;
                if (!owner_req || remaining_q == '0) begin
                    state_d   = S_GAP;
                    timer_d   = CW'(1);
                    y_d       = 1'b0;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else if (timer_q == HP_T) begin
                    state_d = S_OFF;
                    timer_d = CW'(1);
                    y_d     = 1'b0;
                end
            end
            S_OFF: begin
                timer_d = timer_q + 1'b1;
                if (!owner_req || (timer_q == HP_T && remaining_q <= BW'(1))) begin
                    state_d   = S_GAP;
                    timer_d   = CW'(1);
                    y_d       = 1'b0;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else if (timer_q == HP_T) begin
                    remaining_d = remaining_q - 1'b1;
                    state_d     = S_ON;
                    timer_d     = CW'(1);
                    y_d         = 1'b1;
                end
            end
            S_GAP: begin
                timer_d = timer_q + 1'b1;
                y_d     = 1'b0;
                gnt_d   = '0;
                if (timer_q == GAP_T) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            y_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.y       = y_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with HALF_PERIOD=4, GAP=3, NREQ=4.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_led_blink_scheduler;
    localparam int NREQ = 4;
    localparam int BW   = 4;
    localparam int CW   = 16;
    localparam int HP   = 4;
    localparam int GP   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         checks   = 0;
    int         failures = 0;

    led_blink_scheduler_if #(.NREQ(NREQ), .BW(BW)) bus ();

    led_blink_scheduler #(
        .NREQ(NREQ), .BW(BW), .CW(CW), .HALF_PERIOD(HP), .GAP(GP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic set_cnt(input int k, input logic [BW-1:0] v);
        bus.cnt_in[k*BW +: BW] = v;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.req    = '0;
        bus.cnt_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b required=0", bus.busy);
        end
    endtask

    task automatic test_reset();
        bit seen_on;
        rst        = 1'b1;
        bus.req    = '0;
        bus.cnt_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.y, bus.gnt, bus.busy, bus.done, bus.done_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs y=%b gnt=%b busy=%b done=%b id=%0d required all 0",
                     bus.y, bus.gnt, bus.busy, bus.done, bus.done_id);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state state=%0d required=0", dbg_state);
        end
        rst = 1'b0;
        set_cnt(0, 4'd3);
        bus.req = 4'b0001;
        seen_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.y) begin
                seen_on = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_on) begin
            failures++;
            $display("FAIL reset_burst_start y=0 required=1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.y !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_y y=%b required=0", bus.y);
        end
        checks++;
        if (bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_gnt gnt=%b required=0000", bus.gnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_busy busy=%b required=0", bus.busy);
        end
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.y, bus.gnt, bus.busy, bus.done} !== '0) begin
                failures++;
                $display("FAIL post_reset_quiet cycle=%0d y=%b gnt=%b busy=%b done=%b required all 0",
                         i, bus.y, bus.gnt, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_single();
        bit   ok;
        logic y_exp;
        int   rises;
        logic prev_y;
        do_reset();
        set_cnt(0, 4'd3);
        bus.req = 4'b0001;
        wait_grant(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_grant gnt=%b required=0001", bus.gnt);
        end
        rises  = 0;
        prev_y = 1'b0;
        // Sample n=1 is the first cycle after the grant edge.
        for (int n = 1; n <= 32; n++) begin
            if (bus.y && !prev_y) rises++;
            prev_y = bus.y;
            y_exp  = (n <= 20) && ((((n - 1) / 4) % 2) == 0);
            checks++;
            if (bus.y !== y_exp) begin
                failures++;
                $display("FAIL single_y n=%0d y=%b required=%b", n, bus.y, y_exp);
            end
            checks++;
            if (bus.gnt !== ((n <= 24) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL single_gnt n=%0d gnt=%b", n, bus.gnt);
            end
            checks++;
            if (bus.done !== (n == 25)) begin
                failures++;
                $display("FAIL single_done n=%0d done=%b required=%b", n, bus.done, (n == 25));
            end
            checks++;
            if (bus.busy !== (n < 28)) begin
                failures++;
                $display("FAIL single_busy n=%0d busy=%b required=%b", n, bus.busy, (n < 28));
            end
            if (n == 25) begin
                checks++;
                if (bus.done_id !== 3'd0) begin
                    failures++;
                    $display("FAIL single_done_id id=%0d required=0", bus.done_id);
                end
                bus.req = '0;
            end
            @(negedge clk);
        end
        checks++;
        if (rises != 3) begin
            failures++;
            $display("FAIL single_rises rises=%0d required=3", rises);
        end
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        int   dark;
        logic [NREQ-1:0] prev_gnt;
        bit   finished;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_cnt(k, 4'd1);
        bus.req  = 4'b1111;
        dark     = 0;
        prev_gnt = '0;
        finished = 1'b0;
        for (int c = 0; c < 120 && !finished; c++) begin
            @(negedge clk);
            checks++;
            if (!$onehot0(bus.gnt)) begin
                failures++;
                $display("FAIL rr_onehot gnt=%b", bus.gnt);
            end
            if (bus.gnt != '0 && prev_gnt == '0) begin
                if (order.size() > 0) begin
                    checks++;
                    if (dark != GP + 1) begin
                        failures++;
                        $display("FAIL rr_dark_gap dark=%0d required=%0d", dark, GP + 1);
                    end
                end
                for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) order.push_back(k);
                dark = 0;
            end else if (bus.gnt == '0 && order.size() > 0) begin
                dark++;
                checks++;
                if (bus.y !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_dark_y y=%b required=0", bus.y);
                end
            end
            if (bus.done && order.size() == 5) begin
                bus.req  = '0;
                finished = 1'b1;
            end
            prev_gnt = bus.gnt;
        end
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rr_grant_count grants=%0d required=5", order.size());
        end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
                failures++;
                $display("FAIL rr_order slot=%0d got=%0d required=%0d", i, order[i], exp_order[i]);
            end
        end
        wait_idle();
    endtask

    task automatic test_abort();
        int   rises;
        int   done_cnt;
        logic prev_y;
        do_reset();
        set_cnt(2, 4'd5);
        bus.req = 4'b0100;
        rises   = 0;
        prev_y  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.y && !prev_y) rises++;
            prev_y = bus.y;
            if (rises == 2) break;
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 3'd2) begin
            failures++;
            $display("FAIL abort_done done=%b id=%0d required done=1 id=2", bus.done, bus.done_id);
        end
        checks++;
        if (bus.y !== 1'b0 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL abort_release y=%b gnt=%b required y=0 gnt=0000", bus.y, bus.gnt);
        end
        done_cnt = bus.done ? 1 : 0;
        prev_y   = bus.y;
        repeat (15) begin
            @(negedge clk);
            if (bus.y && !prev_y) rises++;
            prev_y = bus.y;
            if (bus.done) done_cnt++;
        end
        checks++;
        if (rises != 2) begin
            failures++;
            $display("FAIL abort_rises rises=%0d required=2", rises);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL abort_done_count count=%0d required=1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        bit ok;
        int y_high;
        int done_cnt;
        do_reset();
        set_cnt(1, 4'd0);
        bus.req = 4'b0010;
        wait_grant(ok);
        checks++;
        if (!ok || bus.gnt !== 4'b0010 || bus.y !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL zero_grant gnt=%b y=%b done=%b required gnt=0010 y=0 done=0",
                     bus.gnt, bus.y, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 3'd1) begin
            failures++;
            $display("FAIL zero_done done=%b id=%0d required done=1 id=1", bus.done, bus.done_id);
        end
        checks++;
        if (bus.gnt !== 4'b0000 || bus.y !== 1'b0) begin
            failures++;
            $display("FAIL zero_release gnt=%b y=%b required gnt=0000 y=0", bus.gnt, bus.y);
        end
        bus.req  = '0;
        y_high   = 0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.y) y_high++;
            if (bus.done) done_cnt++;
        end
        checks++;
        if (y_high != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL zero_quiet y_high=%0d extra_done=%0d required 0 and 0", y_high, done_cnt);
        end
    endtask

    task automatic test_latching();
        bit   ok;
        int   n;
        int   done_n;
        int   rises;
        logic prev_y;
        do_reset();
        set_cnt(0, 4'd2);
        bus.req = 4'b0001;
        wait_grant(ok);
        set_cnt(0, 4'd7);
        n      = 1;
        done_n = 0;
        rises  = bus.y ? 1 : 0;
        prev_y = bus.y;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (bus.y && !prev_y) rises++;
            prev_y = bus.y;
            if (bus.done) begin
                done_n = n;
                break;
            end
        end
        bus.req = '0;
        checks++;
        if (done_n != 2 * 2 * HP + 1) begin
            failures++;
            $display("FAIL latch_done_time n=%0d required=%0d", done_n, 2 * 2 * HP + 1);
        end
        checks++;
        if (rises != 2) begin
            failures++;
            $display("FAIL latch_rises rises=%0d required=2", rises);
        end
        wait_idle();
    endtask

    initial begin
        bus.req    = '0;
        bus.cnt_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_zero_count();
        test_latching();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares one board LED among NREQ requesters, e.g. status, error and heartbeat sources.
- Each requester asks for a burst of N blinks. A round-robin arbiter grants the LED to one requester at a time.
- The granted requester's burst is played at a fixed half-period.
- A mandatory dark gap follows each burst so that consecutive bursts stay visually distinct.

Parameters:
- NREQ, 4: number of requesters (2..8).
- BW, 4: width of each per-requester blink count.
- CW, 16: width of the phase timer.
- HALF_PERIOD, 25000: cycles LED stays on, and cycles it stays off, per blink. Must be >= 1 and < 2^CW.
- GAP, 50000: dark cycles after each burst. Must be >= 1 and < 2^CW.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high until own done.
- cnt_in  in  NREQ*BW  blink counts; requester i uses bits [i*BW +: BW].
- gnt  out  NREQ  one-hot grant; all zero when no owner.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a burst ends, normally or by abort.
- done_id  out  3  index of the requester that done refers to; valid only with done.
- y  out  1  LED drive; 1 = on.

Behaviour:
- Reset (async, rst=1): state=IDLE, y=0, gnt=0, busy=0, done=0, done_id=0, timer=0, remaining=0, rr_ptr=0. Reset mid-burst drops the LED immediately.
- All outputs are registered.
- States: IDLE, ON, OFF, GAP.
- IDLE, any req high:
  - Pick the first requester at or after rr_ptr, searching upward with wrap modulo NREQ.
  - Next edge: gnt one-hot for the winner, remaining=cnt_in of the winner (latched; later changes ignored), rr_ptr=winner+1 mod NREQ.
  - If the latched count is nonzero: state=ON, y=1, timer=1.
  - If the latched count is zero: no blink. Next edge: done=1, done_id=winner, gnt=0, state=GAP, timer=1.
- ON: timer increments each cycle. At timer==HALF_PERIOD the next edge gives state=OFF, y=0, timer=1.
- OFF: timer increments each cycle. At timer==HALF_PERIOD:
  - remaining>1: remaining-=1, state=ON, y=1, timer=1.
  - remaining==1: state=GAP, gnt=0, done=1, done_id=owner, timer=1.
- GAP: y=0, gnt=0. At timer==GAP the next edge gives state=IDLE. An arbitration decision can be made in that same IDLE cycle.
- Abort: if the owner's req is low during ON or OFF, the next edge gives y=0, gnt=0, done=1, done_id=owner, state=GAP, timer=1.
- Requests from non-owners never affect the current burst. They are arbitrated only from IDLE.
- A req that rises during GAP waits for IDLE.
- Timing:
  - One-blink burst latency, grant edge to done pulse: 2*HALF_PERIOD+1 cycles.
  - Each burst of N blinks produces exactly N rising edges on y.
  - y high time = HALF_PERIOD cycles; y low time between blinks = HALF_PERIOD cycles.
- Arithmetic:
  - timer is CW bits unsigned and never wraps under the legal parameter ranges.
  - remaining is BW bits; a count of 2^BW-1 gives 15 blinks at the defaults.
- done is high for exactly one cycle per grant.

Test Plan (HALF_PERIOD=4, GAP=3, NREQ=4):
- Reset: assert rst mid-burst with y=1 -> y, gnt, busy drop asynchronously with no clock edge; after release with no req, all outputs stay 0.
- Single requester: req=0001, cnt0=3 ->
  - 3 pulses on y, each 4 cycles high and 4 low.
  - gnt=0001 throughout.
  - done=1, done_id=0 for one cycle, 25 cycles after the grant edge.
  - busy falls 3 cycles later.
- Round-robin: req=1111 held, all counts=1 ->
  - grant order 0,1,2,3,0.
  - exactly one gnt bit high at any time.
  - >=3 dark cycles between bursts.
- Abort: req=0100, cnt2=5; drop req[2] in the 2nd ON phase -> y=0 and done, done_id=2 on the next edge; only 2 rising edges seen on y.
- Zero count: req=0010, cnt1=0 -> gnt=0010 for one cycle, then done, done_id=1; y never rises.
- Latching: req=0001, cnt0=2; change cnt0 to 7 after the grant -> exactly 2 blinks.
